// File: rtl/byte_merger_pkg.sv
// Shared constants, FSM state encoding and byte-lane placement helper for byte_merger.
// Optional flush support is compiled in with BYTE_MERGER_FLUSH_EN.
package byte_merger_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned CNT_W          = $clog2(BYTES_PER_WORD);
    localparam int unsigned FILL_W         = BYTE_W * (BYTES_PER_WORD - 1);
    localparam int unsigned NB_W           = $clog2(BYTES_PER_WORD + 1);

    typedef enum logic [1:0] {
        ST_FILL,
        ST_HOLD,
        ST_STALL
    } state_e;

    // Bit offset of the byte with arrival index idx inside the assembled word.
    function automatic int unsigned lane_offset(input int unsigned idx, input bit msb_first);
        return msb_first ? (WORD_W - BYTE_W * (idx + 1)) : (BYTE_W * idx);
    endfunction

endpackage

// File: rtl/byte_merger_if.sv
// Byte-in / word-out valid-ready bus for byte_merger.
// BYTE_MERGER_FLUSH_EN adds the flush request and out_bytes count.
interface byte_merger_if;
    import byte_merger_pkg::*;

    logic [BYTE_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

`ifdef BYTE_MERGER_FLUSH_EN
    logic              flush;
    logic [NB_W-1:0]   out_bytes;

    modport master (
        output in_data, in_valid, out_ready, flush,
        input  in_ready, out_data, out_valid, out_bytes
    );
    modport slave (
        input  in_data, in_valid, out_ready, flush,
        output in_ready, out_data, out_valid, out_bytes
    );
`else
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
`endif

endinterface

// File: rtl/byte_merger_outreg.sv
// One-entry valid/ready holding register for the assembled word.
// A load always wins; the caller only loads when the entry is free or being consumed.
module byte_merger_outreg
    import byte_merger_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [WORD_W-1:0] data_i,
`ifdef BYTE_MERGER_FLUSH_EN
    input  logic [NB_W-1:0]   bytes_i,
    output logic [NB_W-1:0]   bytes_o,
`endif
    input  logic              ready_i,
    output logic              valid_o,
    output logic [WORD_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [WORD_W-1:0] data_q, data_d;
`ifdef BYTE_MERGER_FLUSH_EN
    logic [NB_W-1:0]   bytes_q, bytes_d;
`endif

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
`ifdef BYTE_MERGER_FLUSH_EN
        bytes_d = bytes_q;
`endif
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
`ifdef BYTE_MERGER_FLUSH_EN
            bytes_d = bytes_i;
`endif
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
`ifdef BYTE_MERGER_FLUSH_EN
            bytes_q <= '0;
`endif
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
`ifdef BYTE_MERGER_FLUSH_EN
            bytes_q <= bytes_d;
`endif
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
`ifdef BYTE_MERGER_FLUSH_EN
    assign bytes_o = bytes_q;
`endif

endmodule

// File: rtl/byte_merger.sv
// Packs a serial byte stream into 32-bit words; first byte to [31:24] when MSB_FIRST=1.
// BYTE_MERGER_FLUSH_EN adds flush (emit partial word, zero-padded) and out_bytes.
module byte_merger
    import byte_merger_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    byte_merger_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES_PER_WORD - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [WORD_W-1:0] word;
    logic              acc;
    logic              emit;
    logic              busy;
    state_e            state;
`ifdef BYTE_MERGER_FLUSH_EN
    logic [NB_W-1:0]   nbytes;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            fill_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            fill_q <= fill_d;
        end
    end

    // Fill slots are kept in arrival order; lane placement happens only when the word is formed.
    always_comb begin
        int unsigned held;
        held   = 32'(cnt_q);
        cnt_d  = cnt_q;
        fill_d = fill_q;
        word   = '0;
        emit   = acc && (cnt_q == CNT_LAST);
`ifdef BYTE_MERGER_FLUSH_EN
        emit   = emit || (bus.flush && !busy && ((cnt_q != '0) || acc));
        nbytes = NB_W'(held) + NB_W'(acc);
`endif
        for (int unsigned k = 0; k < BYTES_PER_WORD - 1; k++) begin
            if (k < held) begin
                word[lane_offset(k, MSB_FIRST) +: BYTE_W] = fill_q[k*BYTE_W +: BYTE_W];
            end
        end
        if (acc) begin
            word[lane_offset(held, MSB_FIRST) +: BYTE_W] = bus.in_data;
        end
        if (emit) begin
            cnt_d = '0;
        end else if (acc) begin
            fill_d[held*BYTE_W +: BYTE_W] = bus.in_data;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        busy = bus.out_valid && !bus.out_ready;
        if ((cnt_q == CNT_LAST) && busy) begin
            state = ST_STALL;
        end else if (bus.out_valid) begin
            state = ST_HOLD;
        end else begin
            state = ST_FILL;
        end
`ifdef BYTE_MERGER_FLUSH_EN
        bus.in_ready = (state != ST_STALL) && !(busy && bus.flush);
`else
        bus.in_ready = (state != ST_STALL);
`endif
        acc = bus.in_valid && bus.in_ready;
    end

    byte_merger_outreg u_outreg (
        .clk     (clk),
        .reset   (reset),
        .load_i  (emit),
        .data_i  (word),
`ifdef BYTE_MERGER_FLUSH_EN
        .bytes_i (nbytes),
        .bytes_o (bus.out_bytes),
`endif
        .ready_i (bus.out_ready),
        .valid_o (bus.out_valid),
        .data_o  (bus.out_data)
    );

endmodule

// File: tb/tb_byte_merger.sv
// Directed and randomised checks of byte_merger, MSB-first and LSB-first instances side by side.
// Flush scenarios are included when BYTE_MERGER_FLUSH_EN is defined.
module tb_byte_merger;
    import byte_merger_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    byte_merger_if bus ();
    byte_merger_if bus_le ();

    assign bus_le.in_data   = bus.in_data;
    assign bus_le.in_valid  = bus.in_valid;
    assign bus_le.out_ready = bus.out_ready;
`ifdef BYTE_MERGER_FLUSH_EN
    assign bus_le.flush     = bus.flush;
`endif

    byte_merger #(.MSB_FIRST(1'b1)) dut    (.clk(clk), .reset(reset), .bus(bus));
    byte_merger #(.MSB_FIRST(1'b0)) dut_le (.clk(clk), .reset(reset), .bus(bus_le));

    int n_asserts = 0;
    int n_fails   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        tick();
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'hFF;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [7:0]  q[$];
        logic [31:0] exp_w;
        int          sent;
        int          cyc;

        reset         = 1'b1;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
`ifdef BYTE_MERGER_FLUSH_EN
        bus.flush     = 1'b0;
`endif
        tick();
        tick();
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 32'h0);
`ifdef BYTE_MERGER_FLUSH_EN
        chk("rst_out_bytes", bus.out_bytes, 0);
`endif
        reset = 1'b0;

        // Basic word, both byte orders
        bus.out_ready = 1'b1;
        send(8'h86);
        send(8'hDE);
        send(8'hF0);
        chk("t1_not_yet", bus.out_valid, 0);
        send(8'hA3);
        chk("t1_valid", bus.out_valid, 1);
        chk("t1_msb", bus.out_data, 32'h86DEF0A3);
        chk("t1_lsb", bus_le.out_data, 32'hA3F0DE86);
        idle(1);
        chk("t1_consumed", bus.out_valid, 0);
        chk("t1_data_kept", bus.out_data, 32'h86DEF0A3);

        // Back-pressure: second word waits for the first to drain
        bus.out_ready = 1'b0;
        for (int i = 0; i < 7; i++) send(8'(i));
        chk("t2_hold_valid", bus.out_valid, 1);
        chk("t2_hold_data", bus.out_data, 32'h00010203);
        bus.in_data  = 8'h07;
        bus.in_valid = 1'b1;
        #1;
        chk("t2_stall_ready", bus.in_ready, 0);
        tick();
        tick();
        chk("t2_stall_data", bus.out_data, 32'h00010203);
        chk("t2_stall_ready2", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        #1;
        chk("t2_unstall_ready", bus.in_ready, 1);
        tick();
        chk("t2_w2_valid", bus.out_valid, 1);
        chk("t2_w2_data", bus.out_data, 32'h04050607);
        idle(1);
        chk("t2_drained", bus.out_valid, 0);
        chk("t2_data_kept", bus.out_data, 32'h04050607);

        // Full rate, consumer always ready
        for (int i = 0; i < 8; i++) begin
            bus.in_data  = 8'(8'h10 + i);
            bus.in_valid = 1'b1;
            #1;
            chk("t3_in_ready", bus.in_ready, 1);
            tick();
            if (i == 3) chk("t3_w1", bus.out_data, 32'h10111213);
            if (i == 3) chk("t3_w1_valid", bus.out_valid, 1);
            if (i == 4) chk("t3_gap_valid", bus.out_valid, 0);
            if (i == 7) chk("t3_w2", bus.out_data, 32'h14151617);
        end
        idle(1);

        // Gaps between bytes hold the count
        send(8'h01);
        idle(1);
        send(8'h02);
        idle(2);
        chk("t4_gap_valid", bus.out_valid, 0);
        send(8'h03);
        send(8'h04);
        chk("t4_gap_word", bus.out_data, 32'h01020304);
        idle(1);

        // Reset mid-word drops partial bytes
        send(8'h11);
        send(8'h22);
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        chk("t5_rst_ready", bus.in_ready, 1);
        chk("t5_rst_valid", bus.out_valid, 0);
        chk("t5_rst_data", bus.out_data, 32'h0);
        reset = 1'b0;
        send(8'hAA);
        send(8'hBB);
        send(8'hCC);
        chk("t5_partial", bus.out_valid, 0);
        send(8'hDD);
        chk("t5_word", bus.out_data, 32'hAABBCCDD);
        chk("t5_word_lsb", bus_le.out_data, 32'hDDCCBBAA);
        idle(1);

`ifdef BYTE_MERGER_FLUSH_EN
        // Flush of a two-byte partial word, then a full word
        send(8'h5A);
        send(8'hC3);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b1;
        tick();
        bus.flush    = 1'b0;
        chk("f_valid", bus.out_valid, 1);
        chk("f_data", bus.out_data, 32'h5AC30000);
        chk("f_data_lsb", bus_le.out_data, 32'h0000C35A);
        chk("f_bytes", bus.out_bytes, 2);
        send(8'h01);
        send(8'h02);
        send(8'h03);
        send(8'h04);
        chk("f_full", bus.out_data, 32'h01020304);
        chk("f_full_bytes", bus.out_bytes, 4);
        idle(1);
`endif

        // Random gaps and back-pressure against an in-order byte scoreboard
        sent = 0;
        cyc  = 0;
        while ((sent < 1000 || q.size() != 0) && cyc < 20000) begin
            bus.in_valid  = (sent < 1000) && ($urandom_range(0, 1) == 1);
            bus.in_data   = 8'($urandom_range(0, 255));
            bus.out_ready = ($urandom_range(0, 1) == 1);
            #1;
            if (bus.out_valid && bus.out_ready) begin
                chk("rnd_qsize", 32'(q.size() >= 4), 1);
                if (q.size() >= 4) begin
                    exp_w = {q[0], q[1], q[2], q[3]};
                    chk("rnd_word", bus.out_data, exp_w);
                    chk("rnd_word_lsb", bus_le.out_data, {q[3], q[2], q[1], q[0]});
                    repeat (4) void'(q.pop_front());
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(bus.in_data);
                sent++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("rnd_sent", sent, 1000);
        chk("rnd_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
